// File: rtl/spi_exchange.sv
`default_nettype none
// ============================================================================
// Module   : spi_exchange
// Brief    : Full-duplex SPI mode-0 word swap between an internal master and
//            slave shift register. Define XCHG_LSB_FIRST_EN for LSB-first lines.
// Revision : 1.0 - initial release
// ============================================================================
module spi_exchange #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st,
    input  logic [DATA_W-1:0] MASTER_dat,
    input  logic [DATA_W-1:0] SLAVE_dat,
    output logic              SCLK,
    output logic              MOSI,
    output logic              MISO,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] MASTER_rx,
    output logic [DATA_W-1:0] SLAVE_rx
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   master_sr_q, master_sr_d;
    logic [DATA_W-1:0]   slave_sr_q, slave_sr_d;
    logic [DATA_W-1:0]   master_rx_q, master_rx_d;
    logic [DATA_W-1:0]   slave_rx_q, slave_rx_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                sclk_q, sclk_d;
    logic                m_smp_q, m_smp_d;
    logic                s_smp_q, s_smp_d;
    logic                done_q, done_d;

    logic                w_mosi;
    logic                w_miso;
    logic [DATA_W-1:0]   w_master_shift;
    logic [DATA_W-1:0]   w_slave_shift;

`ifdef XCHG_LSB_FIRST_EN
    assign w_mosi         = master_sr_q[0];
    assign w_miso         = slave_sr_q[0];
    assign w_master_shift = {m_smp_q, master_sr_q[DATA_W-1:1]};
    assign w_slave_shift  = {s_smp_q, slave_sr_q[DATA_W-1:1]};
`else
    assign w_mosi         = master_sr_q[DATA_W-1];
    assign w_miso         = slave_sr_q[DATA_W-1];
    assign w_master_shift = {master_sr_q[DATA_W-2:0], m_smp_q};
    assign w_slave_shift  = {slave_sr_q[DATA_W-2:0], s_smp_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            master_sr_q <= '0;
            slave_sr_q  <= '0;
            master_rx_q <= '0;
            slave_rx_q  <= '0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            m_smp_q     <= 1'b0;
            s_smp_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            master_sr_q <= master_sr_d;
            slave_sr_q  <= slave_sr_d;
            master_rx_q <= master_rx_d;
            slave_rx_q  <= slave_rx_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            m_smp_q     <= m_smp_d;
            s_smp_q     <= s_smp_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        master_sr_d = master_sr_q;
        slave_sr_d  = slave_sr_q;
        master_rx_d = master_rx_q;
        slave_rx_d  = slave_rx_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        sclk_d      = sclk_q;
        m_smp_d     = m_smp_q;
        s_smp_d     = s_smp_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (st) state_d = S_LOAD;
            end
            S_LOAD: begin
                master_sr_d = MASTER_dat;
                slave_sr_d  = SLAVE_dat;
                bit_cnt_d   = '0;
                div_d       = '0;
                sclk_d      = 1'b0;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_q == C_DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising SCLK: both ends sample the opposite line.
                        m_smp_d = w_miso;
                        s_smp_d = w_mosi;
                    end else begin
                        master_sr_d = w_master_shift;
                        slave_sr_d  = w_slave_shift;
                        if (bit_cnt_q == C_BIT_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                // done is registered so it rises together with the captured words.
                master_rx_d = master_sr_q;
                slave_rx_d  = slave_sr_q;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Select stays asserted through DONE so it only deasserts for the idle gap.
    assign cs_n      = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign SCLK      = sclk_q;
    assign MOSI      = w_mosi;
    assign MISO      = w_miso;
    assign done      = done_q;
    assign MASTER_rx = master_rx_q;
    assign SLAVE_rx  = slave_rx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_exchange.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_exchange
// Brief    : Self-checking bench for spi_exchange (vector table, random words,
//            back-to-back and mid-transfer reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_exchange;

    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 4;
    localparam int LAT     = 2 + 2 * DATA_W * CLK_DIV;
`ifdef XCHG_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              st;
    logic [DATA_W-1:0] mdat;
    logic [DATA_W-1:0] sdat;
    logic              SCLK, MOSI, MISO, cs_n, busy, done;
    logic [DATA_W-1:0] MASTER_rx, SLAVE_rx;

    spi_exchange #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st         (st),
        .MASTER_dat (mdat),
        .SLAVE_dat  (sdat),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .cs_n       (cs_n),
        .busy       (busy),
        .done       (done),
        .MASTER_rx  (MASTER_rx),
        .SLAVE_rx   (SLAVE_rx)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word as it appears on a serial line, first transmitted bit in the MSB slot.
    function automatic logic [DATA_W-1:0] line_word(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++)
            r[DATA_W-1-i] = LSB_FIRST ? w[i] : w[DATA_W-1-i];
        return r;
    endfunction

    typedef struct {
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] s;
        bit                mid_st;
        logic [DATA_W-1:0] exp_mrx;
        logic [DATA_W-1:0] exp_srx;
        int                exp_lat;
    } vec_t;

    // Observations of the most recent run_xfer call.
    logic [DATA_W-1:0] got_mrx, got_srx, got_mosi, got_miso;
    int got_lat, got_pulses, got_viol, got_extra, got_busy_viol;

    task automatic run_xfer(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] s,
                            input bit mid_st);
        int  k;
        bit  seen;
        logic psclk, pmosi, pmiso;
        got_mrx = 'x; got_srx = 'x; got_mosi = '0; got_miso = '0;
        got_lat = -1; got_pulses = 0; got_viol = 0; got_extra = 0; got_busy_viol = 0;
        @(posedge clk); #1;
        mdat = m; sdat = s; st = 1'b1;
        @(posedge clk); #1;
        k = cyc; st = 1'b0;
        seen = 1'b0;
        psclk = SCLK; pmosi = MOSI; pmiso = MISO;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (i == 2) begin
                mdat = DATA_W'($urandom);
                sdat = DATA_W'($urandom);
            end
            if (mid_st && i == 60) st = 1'b1;
            if (mid_st && i == 61) st = 1'b0;
            if (SCLK && !psclk) begin
                got_pulses++;
                got_mosi = {got_mosi[DATA_W-2:0], MOSI};
                got_miso = {got_miso[DATA_W-2:0], MISO};
                if (MOSI !== pmosi || MISO !== pmiso) got_viol++;
            end
            psclk = SCLK; pmosi = MOSI; pmiso = MISO;
            if (done) begin
                seen    = 1'b1;
                got_lat = cyc - k;
                got_mrx = MASTER_rx;
                got_srx = SLAVE_rx;
            end else if (!busy) begin
                got_busy_viol++;
            end
        end
        for (int j = 0; j < 140; j++) begin
            @(negedge clk);
            if (done) got_extra++;
        end
    endtask

    task automatic check_xfer(input string tag, input logic [DATA_W-1:0] m,
                              input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] emrx,
                              input logic [DATA_W-1:0] esrx, input int elat);
        check({tag, ".master_rx"}, 64'(got_mrx), 64'(emrx));
        check({tag, ".slave_rx"},  64'(got_srx), 64'(esrx));
        check({tag, ".latency"},   64'(got_lat), 64'(elat));
        check({tag, ".sclk_pulses"}, 64'(got_pulses), 64'(DATA_W));
        check({tag, ".mosi_bits"}, 64'(got_mosi), 64'(line_word(m)));
        check({tag, ".miso_bits"}, 64'(got_miso), 64'(line_word(s)));
        check({tag, ".line_change_on_rise"}, 64'(got_viol), 64'd0);
        check({tag, ".extra_done"}, 64'(got_extra), 64'd0);
        check({tag, ".busy_drop"}, 64'(got_busy_viol), 64'd0);
    endtask

    initial begin
        vec_t vecs[5];
        logic [DATA_W-1:0] rm, rs;
        int ndone, cs_hi, falls;
        int dcyc[3];
        int k;
        logic psclk;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h5678, 16'h1234, 130};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 130};
        vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 16'h0000, 130};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h5A5A, 16'hA5A5, 130};
        vecs[4] = '{16'h8001, 16'h7FFE, 1'b1, 16'h7FFE, 16'h8001, 130};

        rst_n = 1'b1; st = 1'b0; mdat = '0; sdat = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset.sclk", 64'(SCLK), 64'd0);
        check("reset.cs_n", 64'(cs_n), 64'd1);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.master_rx", 64'(MASTER_rx), 64'd0);
        check("reset.slave_rx", 64'(SLAVE_rx), 64'd0);
        #10 rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].m, vecs[v].s, vecs[v].mid_st);
            check_xfer($sformatf("vec%0d", v), vecs[v].m, vecs[v].s,
                       vecs[v].exp_mrx, vecs[v].exp_srx, vecs[v].exp_lat);
        end

        // Random words against the swap model.
        for (int r = 0; r < 6; r++) begin
            rm = DATA_W'($urandom);
            rs = DATA_W'($urandom);
            run_xfer(rm, rs, r[0]);
            check_xfer($sformatf("rand%0d", r), rm, rs, rs, rm, LAT);
        end

        // st held high: three back-to-back transfers.
        @(posedge clk); #1;
        mdat = 16'hC3A5; sdat = 16'h0F1E; st = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        ndone = 0; cs_hi = 0;
        for (int i = 0; i < 600 && ndone < 3; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc[ndone] = cyc;
                check($sformatf("b2b%0d.master_rx", ndone), 64'(MASTER_rx), 64'h0F1E);
                check($sformatf("b2b%0d.slave_rx", ndone), 64'(SLAVE_rx), 64'hC3A5);
                ndone++;
            end
            if (ndone >= 1 && ndone < 3 && cs_n) cs_hi++;
        end
        st = 1'b0;
        check("b2b.done_count", 64'(ndone), 64'd3);
        if (ndone == 3) begin
            check("b2b.first_latency", 64'(dcyc[0] - k), 64'(LAT));
            check("b2b.spacing01", 64'(dcyc[1] - dcyc[0]), 64'(LAT + 1));
            check("b2b.spacing12", 64'(dcyc[2] - dcyc[1]), 64'(LAT + 1));
            check("b2b.cs_n_high_cycles", 64'(cs_hi), 64'd2);
        end
        repeat (4) @(negedge clk);

        // Reset after the 7th falling SCLK edge.
        @(posedge clk); #1;
        mdat = 16'h1357; sdat = 16'h2468; st = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        falls = 0;
        psclk = SCLK;
        for (int i = 0; i < 200 && falls < 7; i++) begin
            @(negedge clk);
            if (!SCLK && psclk) falls++;
            psclk = SCLK;
        end
        check("rstmid.falls_reached", 64'(falls), 64'd7);
        rst_n = 1'b0;
        #1;
        check("rstmid.sclk", 64'(SCLK), 64'd0);
        check("rstmid.cs_n", 64'(cs_n), 64'd1);
        check("rstmid.busy", 64'(busy), 64'd0);
        check("rstmid.done", 64'(done), 64'd0);
        check("rstmid.mosi", 64'(MOSI), 64'd0);
        check("rstmid.master_rx", 64'(MASTER_rx), 64'd0);
        check("rstmid.slave_rx", 64'(SLAVE_rx), 64'd0);
        #1 rst_n = 1'b1;
        run_xfer(16'hBEEF, 16'h4C1D, 1'b0);
        check_xfer("after_rst", 16'hBEEF, 16'h4C1D, 16'h4C1D, 16'hBEEF, LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
